// File: rtl/control_unit.sv
// Fetch/decode/execute/writeback sequencer driving the register file.
// Define CTRL_BRANCH_EN to execute opcode 11 as BRZ; otherwise opcode 11 is a NOP.
module control_unit #(
   parameter int unsigned DW  = 2,
   parameter int unsigned PCW = 4
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           RUN,
   output logic [PCW-1:0] IMEM_ADDR,
   input  logic [7:0]     INSTR,
   output logic [1:0]     ADD1,
   output logic [1:0]     ADD2,
   input  logic [DW-1:0]  R1,
   input  logic [DW-1:0]  R2,
   output logic [1:0]     WADD,
   output logic           WEN,
   output logic [DW-1:0]  WDATA,
   output logic           BUSY
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_LDI = 2'b10;
   localparam logic [1:0] OP_BRZ = 2'b11;

   typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;

   state_t         state;
   logic [PCW-1:0] pc;
   logic [7:0]     ir;
   logic [DW-1:0]  opa;
   logic [DW-1:0]  opb;
   logic [DW-1:0]  result;
   logic           wen;
   logic           busy;
   logic [DW-1:0]  alu_res;
   logic [PCW-1:0] brz_pc;

   // ALU: modulo-2^DW arithmetic, carry/borrow dropped
   always_comb begin
      alu_res = opa + opb;
      case (ir[7:6])
         OP_ADD:  alu_res = opa + opb;
         OP_SUB:  alu_res = opa - opb;
         OP_LDI:  alu_res = DW'(ir[1:0]);
         default: alu_res = opa;
      endcase
   end

`ifdef CTRL_BRANCH_EN
   logic [3:0] br_target;

   // Branch target is {rd, imm} truncated/extended to the PC width
   always_comb begin
      br_target = {ir[5:4], ir[1:0]};
      brz_pc    = (opa == '0) ? PCW'(br_target) : pc + PCW'(1);
   end
`else
   always_comb begin
      brz_pc = pc + PCW'(1);
   end
`endif

   // Sequencer; WEN and BUSY are flops, so async reset clears them at once
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= FETCH;
         pc     <= '0;
         ir     <= '0;
         opa    <= '0;
         opb    <= '0;
         result <= '0;
         wen    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (RUN) begin
                  ir    <= INSTR;
                  state <= DECODE;
                  busy  <= 1'b1;
               end
            end
            DECODE: begin
               opa   <= R1;
               opb   <= R2;
               state <= EXECUTE;
            end
            EXECUTE: begin
               if (ir[7:6] == OP_BRZ) begin
                  pc    <= brz_pc;
                  state <= FETCH;
                  busy  <= 1'b0;
               end else begin
                  result <= alu_res;
                  wen    <= 1'b1;
                  state  <= WRITEBACK;
               end
            end
            WRITEBACK: begin
               pc    <= pc + PCW'(1);
               wen   <= 1'b0;
               busy  <= 1'b0;
               state <= FETCH;
            end
            default: begin
               state <= FETCH;
               wen   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign IMEM_ADDR = pc;
   assign ADD1      = ir[3:2];
   assign ADD2      = ir[1:0];
   assign WADD      = ir[5:4];
   assign WDATA     = result;
   assign WEN       = wen;
   assign BUSY      = busy;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with an instruction memory and register file model.
module tb_control_unit;

   logic       clk;
   logic       rst;
   logic       run;
   logic [3:0] imem_addr;
   logic [7:0] instr;
   logic [1:0] add1, add2, wadd, wdata, r1, r2;
   logic       wen, busy;

   logic [7:0] imem [16];
   logic [1:0] rf [4];

   int errors = 0;
   int checks = 0;

   control_unit #(.DW(2), .PCW(4)) dut (
      .CLK(clk), .RST(rst), .RUN(run), .IMEM_ADDR(imem_addr), .INSTR(instr),
      .ADD1(add1), .ADD2(add2), .R1(r1), .R2(r2), .WADD(wadd), .WEN(wen),
      .WDATA(wdata), .BUSY(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign instr = imem[imem_addr];
   assign r1    = rf[add1];
   assign r2    = rf[add2];

   always @(posedge clk) begin
      if (wen) rf[wadd] <= wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Run one instruction from FETCH; count cycles until BUSY drops again
   task automatic exec_one(input string tag, input bit exp_wen, input logic [1:0] exp_wadd,
                           input logic [1:0] exp_wdata, input logic [3:0] exp_pc,
                           input int exp_cyc, input bit drop);
      int cyc = 0;
      int nw  = 0;
      logic [1:0] sa = 2'd0;
      logic [1:0] sd = 2'd0;
      run = 1'b1;
      do begin
         @(negedge clk);
         cyc++;
         if (drop && cyc == 1) run = 1'b0;
         if (wen) begin
            nw++;
            sa = wadd;
            sd = wdata;
         end
      end while (busy && cyc < 12);
      check({tag, "_wen_count"}, 32'(nw), exp_wen ? 32'd1 : 32'd0);
      if (exp_wen) begin
         check({tag, "_wadd"}, 32'(sa), 32'(exp_wadd));
         check({tag, "_wdata"}, 32'(sd), 32'(exp_wdata));
      end
      check({tag, "_pc"}, 32'(imem_addr), 32'(exp_pc));
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
   endtask

   initial begin
      rst = 1'b1;
      run = 1'b0;
      for (int i = 0; i < 16; i++) imem[i] = 8'h00;
      imem[0] = 8'h92;   // LDI r1,2
      imem[1] = 8'h93;   // LDI r1,3
      imem[2] = 8'hA1;   // LDI r2,1
      imem[3] = 8'h36;   // ADD r3,r1,r2 -> 0
      imem[4] = 8'h49;   // SUB r0,r2,r1 -> 2
      imem[5] = 8'hC1;   // BRZ r0 -> 1 (r0=2, not taken)
      imem[6] = 8'h80;   // LDI r0,0
      imem[7] = 8'hC1;   // BRZ r0 -> 1 (r0=0, taken)

      do_reset();
      check("rst_addr", 32'(imem_addr), 0);
      check("rst_add1", 32'(add1), 0);
      check("rst_add2", 32'(add2), 0);
      check("rst_wadd", 32'(wadd), 0);
      check("rst_wdata", 32'(wdata), 0);
      check("rst_wen", 32'(wen), 0);
      check("rst_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_addr", 32'(imem_addr), 0);

      exec_one("ldi_r1_2", 1, 2'd1, 2'd2, 4'd1, 4, 0);
      exec_one("ldi_r1_3", 1, 2'd1, 2'd3, 4'd2, 4, 0);
      exec_one("ldi_r2_1", 1, 2'd2, 2'd1, 4'd3, 4, 0);
      exec_one("add_wrap", 1, 2'd3, 2'd0, 4'd4, 4, 0);
      exec_one("sub_wrap", 1, 2'd0, 2'd2, 4'd5, 4, 0);
      check("rf_r1", 32'(rf[1]), 3);
      check("rf_r2", 32'(rf[2]), 1);
      check("rf_r3", 32'(rf[3]), 0);
      check("rf_r0", 32'(rf[0]), 2);
      exec_one("brz_nz", 0, 2'd0, 2'd0, 4'd6, 3, 0);
      exec_one("ldi_r0_0", 1, 2'd0, 2'd0, 4'd7, 4, 0);
`ifdef CTRL_BRANCH_EN
      exec_one("brz_z", 0, 2'd0, 2'd0, 4'd1, 3, 0);
`else
      exec_one("brz_z", 0, 2'd0, 2'd0, 4'd8, 3, 0);
`endif

      // RUN dropped during DECODE: instruction completes, then parks
      do_reset();
      imem[0] = 8'hB2;   // LDI r3,2
      imem[1] = 8'h91;   // LDI r1,1
      exec_one("run_drop", 1, 2'd3, 2'd2, 4'd1, 4, 1);
      repeat (3) @(negedge clk);
      check("park_busy", 32'(busy), 0);
      check("park_pc", 32'(imem_addr), 1);
      check("park_wen", 32'(wen), 0);
      exec_one("resume", 1, 2'd1, 2'd1, 4'd2, 4, 0);

      // Reset asserted mid-WRITEBACK
      do_reset();
      imem[0] = 8'hA3;   // LDI r2,3
      run = 1'b1;
      repeat (3) @(negedge clk);
      check("wb_reached", 32'(wen), 1);
      run = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_wen", 32'(wen), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_addr", 32'(imem_addr), 0);
      check("arst_wdata", 32'(wdata), 0);
      check("arst_wadd", 32'(wadd), 0);
      check("arst_add1", 32'(add1), 0);
      check("arst_add2", 32'(add2), 0);
      @(negedge clk);
      rst = 1'b0;
      check("arst_no_write", 32'(rf[2]), 1);
      exec_one("restart", 1, 2'd2, 2'd3, 4'd1, 4, 0);

      // PC wrap across 16 LDIs
      do_reset();
      for (int i = 0; i < 16; i++) begin
         logic [3:0] iv;
         iv = 4'(i);
         imem[i] = {2'b10, iv[1:0], 2'b00, iv[3:2]};
      end
      for (int i = 0; i < 16; i++) begin
         logic [3:0] iv;
         logic [3:0] nx;
         iv = 4'(i);
         nx = iv + 4'd1;
         exec_one($sformatf("wrap%0d", i), 1, iv[1:0], iv[3:2], nx, 4, 0);
      end
      check("wrap_addr", 32'(imem_addr), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
